prefetch_issue_queue: RTL and testbench

- Sits directly downstream of the best-offset prefetcher, between its prefetch output and the lower-level cache request port.
- Line-aligns incoming prefetch candidates and drops any that cross a page or duplicate a pending request.
- Buffers accepted requests in a small FIFO and issues them with a valid/ready handshake, yielding to demand traffic.
- Keeps saturating issue and drop counters for performance tuning.

---
 rtl/prefetch_issue_queue.sv | 137 +++++++++++++
 tb/tb_prefetch_issue_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_issue_queue.sv
// Filters, buffers and issues best-offset prefetch candidates toward the lower-level cache.
// Demand traffic blocks new issues but never retracts a request already presented.
module prefetch_issue_queue #(
  parameter int WIDTH     = 64,
  parameter int DEPTH     = 8,
  parameter int LINE_BITS = 6,
  parameter int PAGE_BITS = 12,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pf_valid_i,
  input  logic [WIDTH-1:0]           pf_addr_i,
  input  logic [WIDTH-1:0]           pf_base_addr_i,
  input  logic                       demand_valid_i,
  output logic                       req_valid_o,
  output logic [WIDTH-1:0]           req_addr_o,
  input  logic                       req_ready_i,
  output logic [$clog2(DEPTH):0]     occupancy_o,
  output logic [CNT_WIDTH-1:0]       issued_cnt_o,
  output logic [CNT_WIDTH-1:0]       dup_drop_cnt_o,
  output logic [CNT_WIDTH-1:0]       page_drop_cnt_o,
  output logic [CNT_WIDTH-1:0]       full_drop_cnt_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam logic [WIDTH-1:0] LINE_MASK = {{(WIDTH-LINE_BITS){1'b1}}, {LINE_BITS{1'b0}}};

  typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [PW-1:0]    head, tail;
  logic [OW-1:0]    count;
  logic [WIDTH-1:0] aligned;
  logic             page_hit, dup_hit, full, push, pop, handshake;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign aligned   = pf_addr_i & LINE_MASK;
  assign page_hit  = |((pf_addr_i ^ pf_base_addr_i) >> PAGE_BITS);
  assign full      = (count == OW'(DEPTH));
  assign handshake = req_valid_o & req_ready_i;
  assign push      = pf_valid_i & ~page_hit & ~dup_hit & ~full;
  assign occupancy_o = count;

  // Entries leaving this cycle still count as duplicates.
  always_comb begin
    dup_hit = req_valid_o && (req_addr_o == aligned);
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (mem[i] == aligned)) begin
        dup_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && !demand_valid_i) begin
          pop        = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (handshake) begin
          if ((count != '0) && !demand_valid_i) begin
            pop = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_valid_o <= 1'b0;
      req_addr_o  <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        req_valid_o <= 1'b1;
        req_addr_o  <= mem[head];
      end else if (handshake) begin
        req_valid_o <= 1'b0;
      end
    end
  end

  // Push and pop never target the same slot: push needs not-full, pop needs not-empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (push) begin
        mem[tail]       <= aligned;
        ent_valid[tail] <= 1'b1;
        tail            <= tail + PW'(1);
      end
      if (pop) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      count <= count + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_cnt_o    <= '0;
      dup_drop_cnt_o  <= '0;
      page_drop_cnt_o <= '0;
      full_drop_cnt_o <= '0;
    end else begin
      if (handshake) issued_cnt_o <= sat_inc(issued_cnt_o);
      if (pf_valid_i) begin
        if (page_hit)     page_drop_cnt_o <= sat_inc(page_drop_cnt_o);
        else if (dup_hit) dup_drop_cnt_o  <= sat_inc(dup_drop_cnt_o);
        else if (full)    full_drop_cnt_o <= sat_inc(full_drop_cnt_o);
      end
    end
  end

endmodule

// File: tb/tb_prefetch_issue_queue.sv
// Directed bench: stimulus pushes expected issue addresses into a queue and a
// negedge monitor pops and compares them on each handshake.
module tb_prefetch_issue_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        pf_valid;
  logic [63:0] pf_addr, pf_base;
  logic        demand;
  logic        req_valid;
  logic [63:0] req_addr;
  logic        req_ready;
  logic [3:0]  occupancy;
  logic [15:0] issued_cnt, dup_cnt, page_cnt, full_cnt;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_addr;

  prefetch_issue_queue dut (
    .clk(clk), .rst(rst),
    .pf_valid_i(pf_valid), .pf_addr_i(pf_addr), .pf_base_addr_i(pf_base),
    .demand_valid_i(demand),
    .req_valid_o(req_valid), .req_addr_o(req_addr), .req_ready_i(req_ready),
    .occupancy_o(occupancy),
    .issued_cnt_o(issued_cnt), .dup_drop_cnt_o(dup_cnt),
    .page_drop_cnt_o(page_cnt), .full_drop_cnt_o(full_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // One-cycle candidate pulse; returns 1 time unit after the sampling edge.
  task automatic pulse(input logic [63:0] addr, input logic [63:0] base);
    pf_valid = 1'b1;
    pf_addr  = addr;
    pf_base  = base;
    @(posedge clk); #1;
    pf_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!rst && req_valid && req_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got addr %h, required no request", req_addr);
      end else begin
        exp_addr = exp_q.pop_front();
        if (req_addr !== exp_addr) begin
          n_fail++;
          $display("FAIL issue_addr: got %h, required %h", req_addr, exp_addr);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; pf_valid = 1'b0; pf_addr = '0; pf_base = '0;
    demand = 1'b0; req_ready = 1'b0;
    cycles(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {63'd0, req_valid}, 64'd0);
    check("rst_occ", {60'd0, occupancy}, 64'd0);
    check("rst_issued", {48'd0, issued_cnt}, 64'd0);
    check("rst_drops", {48'd0, dup_cnt | page_cnt | full_cnt}, 64'd0);

    // Single request, 2-cycle latency, one cycle wide
    @(posedge clk); #1;
    req_ready = 1'b1;
    pulse(64'h1047, 64'h1000); exp_q.push_back(64'h1040);
    @(negedge clk);
    check("single_lat1_valid", {63'd0, req_valid}, 64'd0);
    check("single_occ", {60'd0, occupancy}, 64'd1);
    @(negedge clk);
    check("single_valid", {63'd0, req_valid}, 64'd1);
    check("single_addr", req_addr, 64'h1040);
    @(negedge clk);
    check("single_width", {63'd0, req_valid}, 64'd0);
    check("single_issued", {48'd0, issued_cnt}, 64'd1);

    // Page cross
    @(posedge clk); #1;
    pulse(64'h2000, 64'h1FC0);
    cycles(3);
    check("page_cnt", {48'd0, page_cnt}, 64'd1);
    check("page_occ", {60'd0, occupancy}, 64'd0);
    check("page_valid", {63'd0, req_valid}, 64'd0);
    check("page_issued", {48'd0, issued_cnt}, 64'd1);

    // Duplicates against a FIFO entry being popped and the presented register
    req_ready = 1'b0;
    pulse(64'h1040, 64'h1000); exp_q.push_back(64'h1040);
    pulse(64'h1078, 64'h1000);
    pulse(64'h1040, 64'h1000);
    cycles(3);
    check("dup_cnt", {48'd0, dup_cnt}, 64'd2);
    check("dup_occ", {60'd0, occupancy}, 64'd0);
    check("dup_valid", {63'd0, req_valid}, 64'd1);
    check("dup_addr_held", req_addr, 64'h1040);
    req_ready = 1'b1;
    cycles(2);
    check("dup_issued", {48'd0, issued_cnt}, 64'd2);
    check("dup_idle", {63'd0, req_valid}, 64'd0);

    // Full: output register + 8 entries, 10th candidate dropped
    req_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pulse(64'h1000 + 64'(i) * 64'h40, 64'h1000);
      if (i < 9) exp_q.push_back(64'h1000 + 64'(i) * 64'h40);
    end
    @(negedge clk);
    check("full_cnt", {48'd0, full_cnt}, 64'd1);
    check("full_occ", {60'd0, occupancy}, 64'd8);
    check("full_head_addr", req_addr, 64'h1000);
    @(posedge clk); #1;
    req_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("full_b2b_valid", {63'd0, req_valid}, 64'd1);
    end
    @(negedge clk);
    check("full_drain_idle", {63'd0, req_valid}, 64'd0);
    check("full_issued", {48'd0, issued_cnt}, 64'd11);
    check("full_dup_unchanged", {48'd0, dup_cnt}, 64'd2);

    // Demand holds off issue from IDLE
    @(posedge clk); #1;
    demand = 1'b1;
    pulse(64'h3000, 64'h3000); exp_q.push_back(64'h3000);
    pulse(64'h3040, 64'h3000); exp_q.push_back(64'h3040);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("demand_block", {63'd0, req_valid}, 64'd0);
    end
    check("demand_occ", {60'd0, occupancy}, 64'd2);
    @(posedge clk); #1;
    demand = 1'b0;
    @(negedge clk);
    check("demand_release_lat", {63'd0, req_valid}, 64'd0);
    @(negedge clk);
    check("demand_release_valid", {63'd0, req_valid}, 64'd1);
    check("demand_release_addr", req_addr, 64'h3000);
    cycles(3);
    check("demand_drained", {60'd0, occupancy}, 64'd0);
    check("demand_issued", {48'd0, issued_cnt}, 64'd13);

    // Demand raised while PRESENT never retracts the request
    req_ready = 1'b0;
    pulse(64'h4010, 64'h4000); exp_q.push_back(64'h4000);
    pulse(64'h4080, 64'h4000); exp_q.push_back(64'h4080);
    demand = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("present_hold_valid", {63'd0, req_valid}, 64'd1);
      check("present_hold_addr", req_addr, 64'h4000);
    end
    @(posedge clk); #1;
    req_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("present_demand_idle", {63'd0, req_valid}, 64'd0);
    check("present_demand_occ", {60'd0, occupancy}, 64'd1);
    @(posedge clk); #1;
    demand = 1'b0;
    cycles(4);
    check("present_issued", {48'd0, issued_cnt}, 64'd15);
    check("present_idle", {63'd0, req_valid}, 64'd0);

    // Reset while PRESENT with 3 entries queued
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) pulse(64'h5000 + 64'(i) * 64'h40, 64'h5000);
    check("prereset_occ", {60'd0, occupancy}, 64'd3);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {63'd0, req_valid}, 64'd0);
    check("mid_rst_addr", req_addr, 64'd0);
    check("mid_rst_occ", {60'd0, occupancy}, 64'd0);
    check("mid_rst_issued", {48'd0, issued_cnt}, 64'd0);
    check("mid_rst_dup", {48'd0, dup_cnt}, 64'd0);
    check("mid_rst_page", {48'd0, page_cnt}, 64'd0);
    check("mid_rst_full", {48'd0, full_cnt}, 64'd0);

    @(posedge clk); #1;
    req_ready = 1'b1;
    pulse(64'h6004, 64'h6000); exp_q.push_back(64'h6000);
    @(negedge clk);
    check("post_rst_lat1", {63'd0, req_valid}, 64'd0);
    @(negedge clk);
    check("post_rst_valid", {63'd0, req_valid}, 64'd1);
    check("post_rst_addr", req_addr, 64'h6000);
    @(negedge clk);
    check("post_rst_issued", {48'd0, issued_cnt}, 64'd1);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
